// File: rtl/jk_seq_driver_if.sv
// jk_seq_driver_if
//   Command handshake between a requester and jk_seq_driver.
//   cmd_valid : request, held with a stable payload until accepted
//   cmd_ready : sequencer is idle and will accept on the next edge
//   cmd_op    : {j,k} operation (00 hold, 01 reset, 10 set, 11 toggle)
//   cmd_len   : number of edges to apply, minus 1
interface jk_seq_driver_if #(
  parameter int CNT_W = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [CNT_W-1:0] cmd_len;

  modport master (output cmd_valid, output cmd_op, output cmd_len, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_op, input cmd_len, output cmd_ready);
endinterface

// File: rtl/jk_seq_driver.sv
// jk_seq_driver
//   Sequencer feeding a jk_ff. Accepts {j,k} commands with a repeat length,
//   drives j/k for cmd_len+1 clock edges, tracks the expected flip-flop
//   state and checks q feedback once per command.
// Ports:
//   clk      : clock, rising edge
//   preset_n : asynchronous active-low reset (flip-flop preset = ~preset_n)
//   cmd      : command handshake (slave side)
//   j, k     : registered drive to the flip-flop
//   q_fb     : flip-flop q feedback
//   busy     : command in progress (DRIVE or CHECK)
//   done     : one-cycle pulse after a command completes
//   exp_q    : modelled flip-flop state
//   clr_err  : synchronous clear of mismatch / err_cnt
//   mismatch : sticky compare-failure flag
//   err_cnt  : saturating compare-failure count
module jk_seq_driver #(
  parameter int CNT_W = 4,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             preset_n,
  jk_seq_driver_if.slave   cmd,
  output logic             j,
  output logic             k,
  input  logic             q_fb,
  output logic             busy,
  output logic             done,
  output logic             exp_q,
  input  logic             clr_err,
  output logic             mismatch,
  output logic [ERR_W-1:0] err_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_CHECK
  } state_t;

  state_t           state, state_n;
  logic [1:0]       op_r, op_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             j_n, k_n, exp_n, done_n, mm_n;
  logic [ERR_W-1:0] err_n;

  // Decoded from state only, so no input reaches an output combinationally.
  assign cmd.cmd_ready = (state == S_IDLE);
  assign busy          = (state != S_IDLE);

  always_ff @(posedge clk or negedge preset_n) begin
    if (!preset_n) begin
      state    <= S_IDLE;
      op_r     <= '0;
      cnt      <= '0;
      j        <= 1'b0;
      k        <= 1'b0;
      exp_q    <= 1'b0;
      done     <= 1'b0;
      mismatch <= 1'b0;
      err_cnt  <= '0;
    end else begin
      state    <= state_n;
      op_r     <= op_n;
      cnt      <= cnt_n;
      j        <= j_n;
      k        <= k_n;
      exp_q    <= exp_n;
      done     <= done_n;
      mismatch <= mm_n;
      err_cnt  <= err_n;
    end
  end

  always_comb begin
    state_n = state;
    op_n    = op_r;
    cnt_n   = cnt;
    j_n     = j;
    k_n     = k;
    exp_n   = exp_q;
    done_n  = 1'b0;
    mm_n    = mismatch;
    err_n   = err_cnt;

    if (clr_err) begin
      mm_n  = 1'b0;
      err_n = '0;
    end

    case (state)
      S_IDLE: begin
        if (cmd.cmd_valid) begin
          op_n    = cmd.cmd_op;
          cnt_n   = cmd.cmd_len;
          j_n     = cmd.cmd_op[1];
          k_n     = cmd.cmd_op[0];
          state_n = S_DRIVE;
        end
      end
      S_DRIVE: begin
        // Mirror the flip-flop: it samples op_r on this same edge.
        case (op_r)
          2'b01:   exp_n = 1'b0;
          2'b10:   exp_n = 1'b1;
          2'b11:   exp_n = ~exp_q;
          default: exp_n = exp_q;
        endcase
        if (cnt == '0) begin
          j_n     = 1'b0;
          k_n     = 1'b0;
          state_n = S_CHECK;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      S_CHECK: begin
        state_n = S_IDLE;
        done_n  = 1'b1;
        // A failure on the same edge as clr_err overrides the clear.
        if (q_fb != exp_q) begin
          mm_n = 1'b1;
          if (clr_err)
            err_n = ERR_W'(1);
          else if (err_cnt != '1)
            err_n = err_cnt + 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_jk_seq_driver.sv
module tb_jk_seq_driver;

  typedef struct {
    int         cyc;
    logic [1:0] op;
    int         nz;
    logic       eq;
    logic       mm;
    logic [7:0] err;
  } exp_t;

  logic       clk = 1'b0;
  logic       preset_n = 1'b1;
  logic       clr_err = 1'b0;
  logic       fault = 1'b0;
  logic       ffq;
  logic       q_fb;
  logic       j, k, busy, done, exp_q, mismatch;
  logic [7:0] err_cnt;
  logic       j2, k2, busy2, done2, exp_q2, mismatch2;
  logic [1:0] err_cnt2;
  logic       q_fb2;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int nz = 0;
  logic [1:0] last_jk = 2'b00;
  exp_t sb[$];
  exp_t e;
  logic [1:0] sb2[$];
  logic [1:0] e2;

  jk_seq_driver_if #(.CNT_W(4)) if1 ();
  jk_seq_driver_if #(.CNT_W(4)) if2 ();

  jk_seq_driver #(.CNT_W(4), .ERR_W(8)) dut (
    .clk(clk), .preset_n(preset_n), .cmd(if1), .j(j), .k(k), .q_fb(q_fb),
    .busy(busy), .done(done), .exp_q(exp_q), .clr_err(clr_err),
    .mismatch(mismatch), .err_cnt(err_cnt)
  );

  jk_seq_driver #(.CNT_W(4), .ERR_W(2)) dut2 (
    .clk(clk), .preset_n(preset_n), .cmd(if2), .j(j2), .k(k2), .q_fb(q_fb2),
    .busy(busy2), .done(done2), .exp_q(exp_q2), .clr_err(1'b0),
    .mismatch(mismatch2), .err_cnt(err_cnt2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural jk_ff downstream of the driver; preset forces q to 0.
  always @(posedge clk or negedge preset_n) begin
    if (!preset_n) ffq <= 1'b0;
    else begin
      case ({j, k})
        2'b01:   ffq <= 1'b0;
        2'b10:   ffq <= 1'b1;
        2'b11:   ffq <= ~ffq;
        default: ffq <= ffq;
      endcase
    end
  end

  assign q_fb  = fault ? 1'b0 : ffq;
  assign q_fb2 = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor for the main DUT: counts drive cycles, pops on done.
  always @(negedge clk) begin
    if (!preset_n) begin
      nz = 0;
    end else begin
      if (j | k) begin
        nz++;
        last_jk = {j, k};
      end
      if (done) begin
        check("done_expected", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("done_cycle", cyc, e.cyc);
          check("exp_q", exp_q, e.eq);
          check("ff_q", ffq, e.eq);
          check("mismatch", mismatch, e.mm);
          check("err_cnt", err_cnt, e.err);
          check("drive_cycles", nz, e.nz);
          check("drive_jk", last_jk, e.op);
        end
        nz = 0;
      end
    end
  end

  // Monitor for the ERR_W=2 instance.
  always @(negedge clk) begin
    if (preset_n && done2) begin
      check("done2_expected", sb2.size() != 0, 1);
      if (sb2.size() != 0) begin
        e2 = sb2.pop_front();
        check("err_cnt_sat", err_cnt2, e2);
        check("mismatch2", mismatch2, 1);
      end
    end
  end

  task automatic send(input logic [1:0] op, input int len, input bit hold,
                      input bit flt, input bit clr, input bit push,
                      input logic eq, input logic mm, input logic [7:0] err,
                      output int acc);
    int wt;
    @(negedge clk);
    if1.cmd_op    = op;
    if1.cmd_len   = len[3:0];
    if1.cmd_valid = 1'b1;
    wt = 0;
    while (!if1.cmd_ready && wt < 100) begin
      @(negedge clk);
      wt++;
    end
    check("accept_ready", if1.cmd_ready, 1);
    acc = cyc + 1;
    if (push) sb.push_back('{acc + len + 2, op, len + 1, eq, mm, err});
    @(posedge clk);
    #1;
    if (!hold) if1.cmd_valid = 1'b0;
    if (flt || clr) begin
      repeat (len + 1) @(posedge clk);
      @(negedge clk);
      fault   = flt;
      clr_err = clr;
      @(posedge clk);
      #1;
      fault   = 1'b0;
      clr_err = 1'b0;
    end
  endtask

  logic [1:0] sat_tab [4];

  initial begin
    int a1, a2, acc, wt;
    sat_tab = '{2'd1, 2'd2, 2'd3, 2'd3};
    if1.cmd_valid = 1'b0; if1.cmd_op = 2'b00; if1.cmd_len = '0;
    if2.cmd_valid = 1'b0; if2.cmd_op = 2'b00; if2.cmd_len = '0;

    // Mid-cycle reset pulse
    #3 preset_n = 1'b0;
    #1;
    check("rst_ready", if1.cmd_ready, 1);
    check("rst_j", j, 0);
    check("rst_k", k, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_exp_q", exp_q, 0);
    check("rst_mismatch", mismatch, 0);
    check("rst_err_cnt", err_cnt, 0);
    @(negedge clk);
    #2 preset_n = 1'b1;

    //   op     len hold flt clr push eq   mm   err
    send(2'b10, 0, 0, 0, 0, 1, 1'b1, 1'b0, 8'd0, acc);  // set
    send(2'b01, 0, 0, 0, 0, 1, 1'b0, 1'b0, 8'd0, acc);  // reset
    send(2'b11, 2, 0, 0, 0, 1, 1'b1, 1'b0, 8'd0, acc);  // toggle x3: 0->1->0->1
    send(2'b11, 0, 0, 0, 0, 1, 1'b0, 1'b0, 8'd0, acc);  // toggle x1
    send(2'b10, 0, 0, 1, 0, 1, 1'b1, 1'b1, 8'd1, acc);  // set, q forced 0
    send(2'b10, 0, 0, 1, 1, 1, 1'b1, 1'b1, 8'd1, acc);  // failure beats clr_err

    // clr_err alone
    @(negedge clk);
    clr_err = 1'b1;
    @(posedge clk);
    #1 clr_err = 1'b0;
    check("clr_mismatch", mismatch, 0);
    check("clr_err_cnt", err_cnt, 0);

    // Abort a long toggle mid-drive
    send(2'b11, 7, 0, 0, 0, 0, 1'b0, 1'b0, 8'd0, acc);
    repeat (3) @(posedge clk);
    #2 preset_n = 1'b0;
    #1;
    check("abort_j", j, 0);
    check("abort_k", k, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_exp_q", exp_q, 0);
    check("abort_ready", if1.cmd_ready, 1);
    @(negedge clk);
    #2 preset_n = 1'b1;
    send(2'b10, 0, 0, 0, 0, 1, 1'b1, 1'b0, 8'd0, acc);

    // Back-to-back with cmd_valid held
    send(2'b01, 1, 1, 0, 0, 1, 1'b0, 1'b0, 8'd0, a1);
    send(2'b10, 0, 0, 0, 0, 1, 1'b1, 1'b0, 8'd0, a2);
    check("b2b_accept_gap", a2 - a1, 4);

    // Saturation on the ERR_W=2 instance: q_fb tied low, every SET fails
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if2.cmd_op    = 2'b10;
      if2.cmd_len   = '0;
      if2.cmd_valid = 1'b1;
      wt = 0;
      while (!if2.cmd_ready && wt < 100) begin
        @(negedge clk);
        wt++;
      end
      check("dut2_accept_ready", if2.cmd_ready, 1);
      sb2.push_back(sat_tab[i]);
      @(posedge clk);
      #1 if2.cmd_valid = 1'b0;
    end

    wt = 0;
    while ((sb.size() != 0 || sb2.size() != 0) && wt < 200) begin
      @(negedge clk);
      wt++;
    end
    check("scoreboard_drained", sb.size() + sb2.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
